// File: rtl/bayer_pkg.sv
// +---------------------------------------------------------------------------+
// | bayer_pkg : shared defaults and types for the Bayer 3x3 window front-end   |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

package bayer_pkg;

  localparam int DW_DEF    = 8;
  localparam int IMG_W_DEF = 640;
  localparam int SYNC_LAT  = 2;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } sync_t;

  typedef logic [2:0][2:0][DW_DEF-1:0] win3x3_t;

endpackage

`default_nettype wire

// File: rtl/bayer_line_ram.sv
// +---------------------------------------------------------------------------+
// | bayer_line_ram : simple dual-port line buffer, registered read (1 clk)    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module bayer_line_ram
  import bayer_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = IMG_W_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DW-1:0]     i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DW-1:0]     o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Same-address read/write returns the old word, i.e. the previous line.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/bayer_window_3x3.sv
// +---------------------------------------------------------------------------+
// | bayer_window_3x3 : raster RAW to 3x3 neighbourhood with aligned syncs     |
// | Option macro: BAYER_BORDER_REPLICATE_EN (replicate missing top rows)      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module bayer_window_3x3
  import bayer_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vsync,
  input  logic          in_hsync,
  input  logic          in_de,
  input  logic [DW-1:0] in_raw,
  output logic          out_vsync,
  output logic          out_hsync,
  output logic          out_de,
  output logic [DW-1:0] out_p11,
  output logic [DW-1:0] out_p12,
  output logic [DW-1:0] out_p13,
  output logic [DW-1:0] out_p21,
  output logic [DW-1:0] out_p22,
  output logic [DW-1:0] out_p23,
  output logic [DW-1:0] out_p31,
  output logic [DW-1:0] out_p32,
  output logic [DW-1:0] out_p33,
  output logic          out_odd_row,
  output logic          out_odd_col
);

  sync_t                      r_sync [SYNC_LAT];
  logic [ADDR_W-1:0]          r_col_cnt;
  logic                       r_col_sat;
  logic [10:0]                r_row_cnt;
  logic [1:0]                 r_rows_seen;
  logic [1:0]                 r_rows_seen_d1;
  logic [ADDR_W-1:0]          r_col_d1;
  logic                       r_lb1_we;
  logic [DW-1:0]              r_raw_d1;
  logic [1:0]                 r_par_d1;
  logic [1:0]                 r_par_d2;
  logic [2:0][2:0][DW-1:0]    r_win;

  logic          w_de_fall;
  logic          w_vs_rise;
  logic          w_col_last;
  logic          w_lb0_we;
  logic [DW-1:0] w_lb0_rd;
  logic [DW-1:0] w_lb1_rd;
  logic [DW-1:0] w_row1;
  logic [DW-1:0] w_row2;

  assign w_de_fall  = r_sync[0].de & ~in_de;
  assign w_vs_rise  = in_vsync & ~r_sync[0].vsync;
  assign w_col_last = (r_col_cnt == ADDR_W'(IMG_W - 1));
  assign w_lb0_we   = in_de & ~r_col_sat;

  bayer_line_ram #(.DW(DW), .DEPTH(IMG_W), .ADDR_W(ADDR_W)) u_lb0 (
    .clk     (clk),
    .i_we    (w_lb0_we),
    .i_waddr (r_col_cnt),
    .i_wdata (in_raw),
    .i_raddr (r_col_cnt),
    .o_rdata (w_lb0_rd)
  );

  // lb1 is fed one clock late from lb0's read port, so its write address is delayed too.
  bayer_line_ram #(.DW(DW), .DEPTH(IMG_W), .ADDR_W(ADDR_W)) u_lb1 (
    .clk     (clk),
    .i_we    (r_lb1_we),
    .i_waddr (r_col_d1),
    .i_wdata (w_lb0_rd),
    .i_raddr (r_col_cnt),
    .o_rdata (w_lb1_rd)
  );

  always_comb begin
    w_row1 = w_lb1_rd;
    w_row2 = w_lb0_rd;
`ifdef BAYER_BORDER_REPLICATE_EN
    if (r_rows_seen_d1 == 2'd0) begin
      w_row1 = r_raw_d1;
      w_row2 = r_raw_d1;
    end else if (r_rows_seen_d1 == 2'd1) begin
      w_row1 = w_lb0_rd;
    end
`else
    if (r_rows_seen_d1 == 2'd0) begin
      w_row1 = '0;
      w_row2 = '0;
    end else if (r_rows_seen_d1 == 2'd1) begin
      w_row1 = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_LAT; i++) r_sync[i] <= '0;
      r_col_cnt      <= '0;
      r_col_sat      <= 1'b0;
      r_row_cnt      <= '0;
      r_rows_seen    <= '0;
      r_rows_seen_d1 <= '0;
      r_col_d1       <= '0;
      r_lb1_we       <= 1'b0;
      r_raw_d1       <= '0;
      r_par_d1       <= '0;
      r_par_d2       <= '0;
      r_win          <= '0;
    end else begin
      r_sync[0] <= '{vsync: in_vsync, hsync: in_hsync, de: in_de};
      for (int i = 1; i < SYNC_LAT; i++) r_sync[i] <= r_sync[i-1];

      if (w_de_fall) begin
        r_col_cnt <= '0;
        r_col_sat <= 1'b0;
      end else if (in_de) begin
        if (w_col_last) r_col_sat <= 1'b1;
        else            r_col_cnt <= r_col_cnt + 1'b1;
      end

      // Frame start overrides a coincident end-of-line.
      if (w_vs_rise) begin
        r_row_cnt   <= '0;
        r_rows_seen <= '0;
      end else if (w_de_fall) begin
        r_row_cnt <= r_row_cnt + 1'b1;
        if (r_rows_seen != 2'd2) r_rows_seen <= r_rows_seen + 1'b1;
      end

      r_rows_seen_d1 <= r_rows_seen;
      r_col_d1       <= r_col_cnt;
      r_lb1_we       <= w_lb0_we;
      r_raw_d1       <= in_raw;
      r_par_d1       <= {r_row_cnt[0], r_col_cnt[0]};
      r_par_d2       <= r_par_d1;

      if (r_sync[0].de) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_row1;
        r_win[1][2] <= w_row2;
        r_win[2][2] <= r_raw_d1;
      end
    end
  end

  assign out_vsync   = r_sync[SYNC_LAT-1].vsync;
  assign out_hsync   = r_sync[SYNC_LAT-1].hsync;
  assign out_de      = r_sync[SYNC_LAT-1].de;
  assign out_odd_row = r_par_d2[1];
  assign out_odd_col = r_par_d2[0];
  assign out_p11     = r_win[0][0];
  assign out_p12     = r_win[0][1];
  assign out_p13     = r_win[0][2];
  assign out_p21     = r_win[1][0];
  assign out_p22     = r_win[1][1];
  assign out_p23     = r_win[1][2];
  assign out_p31     = r_win[2][0];
  assign out_p32     = r_win[2][1];
  assign out_p33     = r_win[2][2];

endmodule

`default_nettype wire

// File: tb/tb_bayer_window_3x3.sv
// +---------------------------------------------------------------------------+
// | tb_bayer_window_3x3 : directed self-checking bench for bayer_window_3x3   |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_bayer_window_3x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_vsync, in_hsync, in_de;
  logic [7:0] in_raw;
  logic       out_vsync, out_hsync, out_de, out_odd_row, out_odd_col;
  logic [7:0] out_p11, out_p12, out_p13, out_p21, out_p22, out_p23, out_p31, out_p32, out_p33;

  int n_tests = 0;
  int n_fail  = 0;

  logic [71:0] cap_win [4][16];
  logic [1:0]  cap_par [4][16];
  logic        pv_de   = 1'b0;
  int          pv_line = 0;
  int          pv_col  = 0;

  typedef struct {
    int          line;
    int          col;
    logic [71:0] taps;
    logic [1:0]  par;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  bayer_window_3x3 #(.DW(8), .IMG_W(8), .ADDR_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vsync    (in_vsync),
    .in_hsync    (in_hsync),
    .in_de       (in_de),
    .in_raw      (in_raw),
    .out_vsync   (out_vsync),
    .out_hsync   (out_hsync),
    .out_de      (out_de),
    .out_p11     (out_p11),
    .out_p12     (out_p12),
    .out_p13     (out_p13),
    .out_p21     (out_p21),
    .out_p22     (out_p22),
    .out_p23     (out_p23),
    .out_p31     (out_p31),
    .out_p32     (out_p32),
    .out_p33     (out_p33),
    .out_odd_row (out_odd_row),
    .out_odd_col (out_odd_col)
  );

  function automatic logic [71:0] taps();
    return {out_p11, out_p12, out_p13, out_p21, out_p22, out_p23, out_p31, out_p32, out_p33};
  endfunction

  function automatic logic [76:0] all_outs();
    return {out_vsync, out_hsync, out_de, out_odd_row, out_odd_col, taps()};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs after a call belong to the pixel driven one call earlier.
  task automatic drive(input logic vs, input logic hs, input logic de, input logic [7:0] raw,
                       input int line, input int col);
    in_vsync = vs;
    in_hsync = hs;
    in_de    = de;
    in_raw   = raw;
    @(posedge clk);
    #1;
    if (pv_de) begin
      cap_win[pv_line][pv_col] = taps();
      cap_par[pv_line][pv_col] = {out_odd_row, out_odd_col};
    end
    pv_de   = de;
    pv_line = line;
    pv_col  = col;
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic send_line(input int line, input int w, input logic [7:0] base);
    for (int c = 0; c < w; c++) drive(1'b0, 1'b0, 1'b1, base + 8'(c), line, c);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  initial begin
    vecs[0] = '{2, 5, 72'h03_04_05_13_14_15_23_24_25, 2'b01};
    vecs[1] = '{3, 7, 72'h15_16_17_25_26_27_35_36_37, 2'b11};
    vecs[5] = '{3, 1, 72'h07_10_11_17_20_21_27_30_31, 2'b11};
`ifdef BAYER_BORDER_REPLICATE_EN
    vecs[2] = '{0, 3, 72'h01_02_03_01_02_03_01_02_03, 2'b01};
    vecs[3] = '{1, 2, 72'h00_01_02_00_01_02_10_11_12, 2'b10};
    vecs[4] = '{2, 0, 72'h06_07_00_06_07_10_16_17_20, 2'b00};
`else
    vecs[2] = '{0, 3, 72'h00_00_00_00_00_00_01_02_03, 2'b01};
    vecs[3] = '{1, 2, 72'h00_00_00_00_01_02_10_11_12, 2'b10};
    vecs[4] = '{2, 0, 72'h00_00_00_06_07_10_16_17_20, 2'b00};
`endif

    rst_n = 1'b0; in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; in_raw = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 80'(all_outs()), 80'h0);
    rst_n = 1'b1;

    // Sync delay and single-pixel latency.
    drive(1'b1, 1'b1, 1'b0, 8'h00, 0, 0);
    chk("sync_t1", 80'({out_vsync, out_hsync}), 80'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    chk("sync_t2", 80'({out_vsync, out_hsync}), 80'h3);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    chk("sync_t3", 80'({out_vsync, out_hsync}), 80'h0);
    drive(1'b0, 1'b0, 1'b1, 8'hA5, 0, 0);
    chk("lat_t1_de", 80'(out_de), 80'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    chk("lat_t2_de_p33", 80'({out_de, out_p33}), 80'h1A5);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    chk("lat_t3_de", 80'(out_de), 80'h0);

    // Top border on the first line of a frame.
    start_frame();
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b1, 8'h3C, 0, c);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
`ifdef BAYER_BORDER_REPLICATE_EN
    chk("top_border", 80'(taps()), 80'h3C3C3C_3C3C3C_3C3C3C);
`else
    chk("top_border", 80'(taps()), 80'h000000_000000_3C3C3C);
`endif

    // Ramp frame, 8x4, pixel = row*16 + col.
    start_frame();
    for (int l = 0; l < 4; l++) send_line(l, 8, 8'(l * 16));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ramp_taps_L%0d_C%0d", vecs[i].line, vecs[i].col),
          80'(cap_win[vecs[i].line][vecs[i].col]), 80'(vecs[i].taps));
      chk($sformatf("ramp_par_L%0d_C%0d", vecs[i].line, vecs[i].col),
          80'(cap_par[vecs[i].line][vecs[i].col]), 80'(vecs[i].par));
    end

    // Parity over a 4x4 frame.
    start_frame();
    for (int l = 0; l < 4; l++) send_line(l, 4, 8'h00);
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("parity_L%0d_C%0d", l, c), 80'(cap_par[l][c]), 80'({l[0], c[0]}));

    // Vsync rise on the same cycle as de fall.
    start_frame();
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b1, 8'(c), 0, c);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    send_line(1, 4, 8'h00);
    chk("vs_coincide_c0", 80'(cap_par[1][0]), 80'h0);
    chk("vs_coincide_c1", 80'(cap_par[1][1]), 80'h1);

    // Overlong line: 11 pixels into an 8-deep line buffer.
    start_frame();
    send_line(0, 11, 8'h40);
    send_line(1, 8, 8'h80);
    chk("overlong_c5_row2", 80'(cap_win[1][5][47:24]), 80'h434445);
    chk("overlong_c7_row2", 80'(cap_win[1][7][47:24]), 80'h454647);
    chk("overlong_c7_row3", 80'(cap_win[1][7][23:0]), 80'h858687);

    // Asynchronous reset in the middle of a line.
    start_frame();
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b1, 8'h10 + 8'(c), 0, c);
    rst_n = 1'b0;
    #1;
    chk("rst_async_zero", 80'(all_outs()), 80'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 8'h20 + 8'(i), 0, 4 + i);
    chk("rst_hold_zero", 80'(all_outs()), 80'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'h30, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 8'h31, 0, 1);
    drive(1'b0, 1'b0, 1'b1, 8'h32, 0, 2);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
`ifdef BAYER_BORDER_REPLICATE_EN
    chk("rst_restart_win", 80'({out_de, taps()}), {8'h01, 72'h303132_303132_303132});
`else
    chk("rst_restart_win", 80'({out_de, taps()}), {8'h01, 72'h000000_000000_303132});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
